// File: rtl/axis_skid_stage_pkg.sv
// Shared definitions for the AXI-Stream skid stage.
// State encodings and default widths.
package axis_skid_stage_pkg;

  localparam int DEF_WORD_WIDTH  = 32;
  localparam int DEF_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/axis_skid_stage_if.sv
// AXI-Stream beat bundle with valid/ready handshake.
// The master drives payload and valid; the slave drives ready.
interface axis_skid_stage_if
  import axis_skid_stage_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
);

  logic                  valid;
  logic                  ready;
  logic [WORD_WIDTH-1:0] data;
  logic                  last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/axis_skid_stage_reg.sv
// Clock-enabled register with asynchronous active-low reset.
// Used for the main and skid payload holding registers.
module axis_skid_stage_reg #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load only when enabled; reset to the configured value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/axis_skid_stage.sv
// Two-entry registered AXI-Stream skid stage.
// Registers both forward and backward paths; counts m-side beats.
module axis_skid_stage
  import axis_skid_stage_pkg::*;
#(
  parameter int                    WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int                    COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter logic [WORD_WIDTH-1:0] RESET_DATA  = '0
) (
  input  logic                   clock,
  input  logic                   resetn,
  axis_skid_stage_if.slave       s,
  axis_skid_stage_if.master      m,
  input  logic                   count_clear,
  output logic [COUNT_WIDTH-1:0] beat_count
);

  localparam int RW = WORD_WIDTH + 1;
  localparam logic [RW-1:0] RST_BEAT = {1'b0, RESET_DATA};
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  skid_state_e state;
  skid_state_e state_nx;

  logic          s_ready_q;
  logic          m_valid_q;
  logic          in_fire;
  logic          out_fire;
  logic          main_en;
  logic          skid_en;
  logic [RW-1:0] s_beat;
  logic [RW-1:0] main_d;
  logic [RW-1:0] main_q;
  logic [RW-1:0] skid_q;

  assign s_beat   = {s.last, s.data};
  assign in_fire  = s.valid & s_ready_q;
  assign out_fire = m_valid_q & m.ready;

  // Next state and payload register enables.
  always_comb begin
    state_nx = state;
    main_en  = 1'b0;
    skid_en  = 1'b0;
    main_d   = s_beat;
    unique case (1'b1)
      state == SKID_EMPTY: begin
        if (in_fire) begin
          state_nx = SKID_BUSY;
          main_en  = 1'b1;
        end
      end
      state == SKID_BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          state_nx = SKID_FULL;
          skid_en  = 1'b1;
        end else if (out_fire) begin
          state_nx = SKID_EMPTY;
        end
      end
      state == SKID_FULL: begin
        if (out_fire) begin
          state_nx = SKID_BUSY;
          main_en  = 1'b1;
          main_d   = skid_q;
        end
      end
      default: begin
        state_nx = SKID_EMPTY;
      end
    endcase
  end

  // State plus registered handshake outputs derived from next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= SKID_EMPTY;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state     <= state_nx;
      s_ready_q <= (state_nx != SKID_FULL);
      m_valid_q <= (state_nx != SKID_EMPTY);
    end
  end

  // Saturating beat counter; clear wins over a coincident beat.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      beat_count <= '0;
    end else if (count_clear) begin
      beat_count <= '0;
    end else if (out_fire && beat_count != CNT_MAX) begin
      beat_count <= beat_count + 1'b1;
    end
  end

  axis_skid_stage_reg #(
    .WIDTH      (RW),
    .RESET_VALUE(RST_BEAT)
  ) u_main (
    .clock (clock),
    .resetn(resetn),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  axis_skid_stage_reg #(
    .WIDTH      (RW),
    .RESET_VALUE(RST_BEAT)
  ) u_skid (
    .clock (clock),
    .resetn(resetn),
    .en    (skid_en),
    .d     (s_beat),
    .q     (skid_q)
  );

  assign s.ready = s_ready_q;
  assign m.valid = m_valid_q;
  assign m.data  = main_q[WORD_WIDTH-1:0];
  assign m.last  = main_q[WORD_WIDTH];

endmodule

// File: tb/tb_axis_skid_stage.sv
// Scoreboard bench for axis_skid_stage.
// Directed phases plus a random valid/ready soak.
module tb_axis_skid_stage;
  import axis_skid_stage_pkg::*;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          count_clear = 1'b0;
  logic [CW-1:0] beat_count;

  axis_skid_stage_if #(.WORD_WIDTH(W)) s_if ();
  axis_skid_stage_if #(.WORD_WIDTH(W)) m_if ();

  axis_skid_stage #(
    .WORD_WIDTH (W),
    .COUNT_WIDTH(CW),
    .RESET_DATA ('0)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .s          (s_if),
    .m          (m_if),
    .count_clear(count_clear),
    .beat_count (beat_count)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fail = 0;
  int         out_beats = 0;
  logic [W:0] sb[$];
  logic [CW-1:0] exp_count = '0;
  bit         stall_prev = 0;
  bit         rst_prev = 0;
  bit         check_ready_hi = 0;
  logic [W:0] prev_beat = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one beat; push expectation when the handshake is certain.
  task automatic send(input logic [W-1:0] d, input logic l);
    int n;
    n = 0;
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.last  = l;
    forever begin
      @(negedge clock);
      if (s_if.ready) begin
        sb.push_back({l, d});
        break;
      end
      n++;
      if (n > 1000) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got no s_ready expected accept");
        break;
      end
    end
    @(posedge clock);
    #1;
    s_if.valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // Monitor: pops on each output handshake, checks stall and counter.
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        exp_count  = '0;
        stall_prev = 0;
        rst_prev   = 0;
      end else begin
        chk("beat_count", beat_count, exp_count);
        if (rst_prev)
          chk("ready_low_iff_full", !s_if.ready,
              dut.state == SKID_FULL);
        if (stall_prev) begin
          chk("stall_valid", m_if.valid, 1);
          chk("stall_beat", {m_if.last, m_if.data}, prev_beat);
        end
        if (check_ready_hi)
          chk("stream_s_ready", s_if.ready, 1);
        if (m_if.valid && m_if.ready) begin
          out_beats++;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_beat: got %0h expected none",
                     {m_if.last, m_if.data});
          end else begin
            e = sb.pop_front();
            chk("out_beat", {m_if.last, m_if.data}, e);
          end
        end
        if (count_clear)
          exp_count = '0;
        else if (m_if.valid && m_if.ready && exp_count != '1)
          exp_count = exp_count + 1'b1;
        stall_prev = m_if.valid && !m_if.ready;
        prev_beat  = {m_if.last, m_if.data};
        rst_prev   = 1;
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit rnd_done;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b0;
    resetn     = 1'b0;

    repeat (3) begin
      @(posedge clock);
      #1;
      chk("rst_m_valid", m_if.valid, 0);
      chk("rst_s_ready", s_if.ready, 0);
      chk("rst_count", beat_count, 0);
    end
    @(negedge clock);
    #2 resetn = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_s_ready", s_if.ready, 1);
    chk("post_rst_m_valid", m_if.valid, 0);

    // Streaming with sink always ready.
    m_if.ready = 1'b1;
    check_ready_hi = 1;
    base = out_beats;
    for (int i = 1; i <= 8; i++) send(W'(i), i == 8);
    @(negedge clock);
    #1;
    chk("stream_beats", out_beats - base, 8);
    check_ready_hi = 0;
    @(posedge clock);
    #1;
    chk("stream_count", beat_count, 8);

    // Backpressure into the skid register.
    base = out_beats;
    fork
      begin
        for (int i = 0; i < 6; i++) send(W'(32'hA0 + i), i == 5);
      end
      begin
        int n;
        n = 0;
        do begin
          @(posedge clock);
          #1;
          n++;
        end while (!(m_if.valid && m_if.data == 32'hA1) && n < 50);
        chk("bp_see_a1", m_if.data, 32'hA1);
        m_if.ready = 1'b0;
        @(posedge clock);
        #1;
        chk("bp_s_ready", s_if.ready, 0);
        chk("bp_state", dut.state, SKID_FULL);
        chk("bp_skid", dut.skid_q[W-1:0], 32'hA2);
        chk("bp_hold", m_if.data, 32'hA1);
        repeat (3) begin
          @(posedge clock);
          #1;
          chk("bp_hold", m_if.data, 32'hA1);
        end
        m_if.ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_beats", out_beats - base, 6);

    // Random valid/ready soak.
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          while ($urandom_range(0, 1) == 1) begin
            @(posedge clock);
            #1;
          end
          send($urandom, (i % 16) == 15);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock);
          #1;
          m_if.ready = ($urandom_range(0, 1) == 1);
        end
        m_if.ready = 1'b1;
      end
    join
    wait_drain();

    // Counter saturation and clear priority.
    @(posedge clock);
    #1 count_clear = 1'b1;
    @(posedge clock);
    #1 count_clear = 1'b0;
    chk("clr_count", beat_count, 0);
    for (int i = 0; i < 20; i++) send(W'(32'h300 + i), i == 19);
    wait_drain();
    @(posedge clock);
    #1;
    chk("sat_count", beat_count, 15);
    count_clear = 1'b1;
    @(posedge clock);
    #1 count_clear = 1'b0;
    chk("clr_count2", beat_count, 0);
    send(32'h10, 1'b0);
    send(32'h11, 1'b1);
    chk("pre_clr_count", beat_count, 1);
    count_clear = 1'b1;
    @(posedge clock);
    #1 count_clear = 1'b0;
    chk("clr_fire_count", beat_count, 0);
    wait_drain();

    // Asynchronous reset while FULL.
    m_if.ready = 1'b0;
    send(32'h44, 1'b0);
    send(32'h55, 1'b1);
    chk("mid_state", dut.state, SKID_FULL);
    chk("mid_skid", dut.skid_q[W-1:0], 32'h55);
    #3 resetn = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_if.valid, 0);
    chk("mid_rst_s_ready", s_if.ready, 0);
    sb.delete();
    base = out_beats;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2 resetn = 1'b1;
    @(posedge clock);
    #1;
    m_if.ready = 1'b1;
    chk("after_rst_m_valid", m_if.valid, 0);
    send(32'h77, 1'b1);
    wait_drain();
    repeat (3) @(posedge clock);
    #1;
    chk("after_rst_beats", out_beats - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_skid_stage.md
Name: axis_skid_stage

Overview:
- Registered AXI-Stream pipeline stage (two-entry skid buffer) that drives the enables of the team's clock-enabled data registers.
- Cuts both the forward path (s_valid/s_data to m_valid/m_data) and the backward path (m_ready to s_ready) with registers.
- Sustains 1 beat/cycle with no bubbles.
- Inserted between convolution-engine stages and at the DMA boundary to close timing.
- Includes a saturating beat counter for bring-up and profiling.

Parameters:
- WORD_WIDTH, 32: width of s_data/m_data.
- COUNT_WIDTH, 16: width of beat_count.
- RESET_DATA, 0: reset value of the main and skid data registers.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  reset.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  stage can accept; registered.
- s_data  in  WORD_WIDTH  upstream payload.
- s_last  in  1  end of packet.
- m_valid  out  1  downstream beat valid; registered.
- m_ready  in  1  downstream accepts.
- m_data  out  WORD_WIDTH  payload; registered.
- m_last  out  1  end of packet; registered.
- count_clear  in  1  synchronous clear of beat_count.
- beat_count  out  COUNT_WIDTH  number of m-side handshakes; saturating.
- Interface decision: reset resetn, asynchronous, active-low; clock clock.

Behaviour:
- Reset (resetn low, asynchronous):
  - state=EMPTY, m_valid=0, s_ready=0.
  - m_data=skid_data=RESET_DATA, m_last=skid_last=0, beat_count=0.
  - At the first posedge after resetn rises: s_ready=1.
- Handshake definitions: in_fire = s_valid&s_ready; out_fire = m_valid&m_ready.
- AXI rules:
  - m_valid, m_data and m_last are held stable while m_valid&!m_ready.
  - m_valid never depends combinationally on m_ready.
- States:
  - EMPTY: m_valid=0, s_ready=1.
  - BUSY: m_valid=1, s_ready=1, skid unused.
  - FULL: m_valid=1, s_ready=0, skid holds one beat.
- Transitions (evaluated each posedge):
  - EMPTY & in_fire -> BUSY; main reg <= s_data/s_last.
  - BUSY & in_fire & out_fire -> BUSY; main reg <= s.
  - BUSY & in_fire & !out_fire -> FULL; skid reg <= s; main reg held.
  - BUSY & !in_fire & out_fire -> EMPTY.
  - FULL & out_fire -> BUSY; main reg <= skid.
  - All other cases: hold state and data.
- Outputs:
  - s_ready is the registered value of (next_state != FULL), plus the post-reset rule above.
  - m_valid is the registered value of (next_state != EMPTY).
- Latency and ordering: 1 cycle s-side to m-side when empty. Beats are delivered in order, none dropped or duplicated.
- Register enables: main and skid data registers are loaded only via their clock enables as listed above. No data-path reset is required beyond RESET_DATA.
- beat_count:
  - Increments by 1 on out_fire.
  - Saturates at all-ones.
  - count_clear has priority: a clear coinciding with out_fire yields 0, and that beat is not counted.
- Reset mid-transfer: all beats in flight are discarded. No output glitch after release; the block is in EMPTY.
- m_last travels with its data through both registers unchanged.

Decomposition:
- Shared package (params header):
  - 2-bit state encodings SKID_EMPTY=0, SKID_BUSY=1, SKID_FULL=2.
  - Default WORD_WIDTH and COUNT_WIDTH.
- Data registers (main, skid):
  - Instances of the team's standard clock-enabled register primitive, built with its async-reset variant.
  - Widths WORD_WIDTH+1 ({last,data}).
- Control FSM and counter live in this module. No further sub-module.

Test Plan:
- Reset then idle:
  - resetn low for 3 cycles, then released -> m_valid=0 throughout.
  - s_ready=0 during reset and =1 at the first posedge after release.
  - beat_count=0.
- Streaming, sink always ready:
  - s_valid=1 and m_ready=1 continuously; data 1..8 with s_last on 8.
  - m_data shows 1..8 on consecutive cycles, lagging by 1 cycle; m_last is set only with 8; s_ready stays 1; beat_count=8.
- Backpressure and skid:
  - Stream 0xA0..0xA5; drop m_ready for 4 cycles after 0xA1 appears.
  - State goes to FULL holding 0xA2; s_ready=0 the next cycle.
  - m_data held at 0xA1; no loss; output order is A0..A5.
- Random valid/ready (10k beats, 50% toggle on each side):
  - Scoreboard matches in order.
  - Assertions hold: m_data stable under stall; s_ready=0 only in FULL.
- Counter:
  - COUNT_WIDTH=4: send 20 beats -> beat_count saturates at 15.
  - count_clear together with out_fire -> beat_count=0 the next cycle.
- Reset mid-operation:
  - Assert resetn low asynchronously while in FULL with 0x55 in skid.
  - m_valid drops immediately; after release, the next beat 0x77 appears alone; 0x55 is never emitted.
